// File: rtl/program_seq_unit.sv
`default_nettype none
// ============================================================================
// Module      : program_seq_unit
// Description : Program counter sequencer with increment, jump, call/return
//               and a small return-address stack. Overflow and underflow
//               are reported as sticky error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module program_seq_unit #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_ADDR  = 0
) (
    input  logic                                 clk,
    input  logic                                 reset_p,
    input  logic                                 pc_inc,
    input  logic                                 load_pc,
    input  logic                                 call,
    input  logic                                 ret,
    input  logic                                 clr_err,
    input  logic                                 pc_rd_en,
    input  logic [ADDR_W-1:0]                    pc_in,
    output logic [ADDR_W-1:0]                    pc_out,
    output logic [ADDR_W-1:0]                    pc_cur,
    output logic [$clog2(STACK_DEPTH+1)-1:0]     sp,
    output logic                                 stack_empty,
    output logic                                 stack_full,
    output logic                                 stack_ovf,
    output logic                                 stack_unf
);

    localparam int                  c_sp_w     = $clog2(STACK_DEPTH + 1);
    localparam int                  c_idx_w    = $clog2(STACK_DEPTH);
    localparam logic [c_sp_w-1:0]   c_depth    = c_sp_w'(STACK_DEPTH);
    localparam logic [c_sp_w-1:0]   c_sp_one   = c_sp_w'(1);
    localparam logic [ADDR_W-1:0]   c_pc_one   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0]   c_reset_pc = ADDR_W'(RESET_ADDR);

    logic [ADDR_W-1:0]  r_pc;
    logic [c_sp_w-1:0]  r_sp;
    logic [ADDR_W-1:0]  r_stack [STACK_DEPTH];
    logic               r_ovf;
    logic               r_unf;

    logic [ADDR_W-1:0]  w_pc_plus1;
    logic [ADDR_W-1:0]  w_pc_nxt;
    logic [c_sp_w-1:0]  w_sp_nxt;
    logic [c_idx_w-1:0] w_push_idx;
    logic [c_idx_w-1:0] w_top_idx;
    logic               w_empty;
    logic               w_full;
    logic               w_do_push;
    logic               w_do_pop;
    logic               w_ovf_set;
    logic               w_unf_set;

    // Stack status comes straight from the pointer so it can never disagree.
    assign w_empty    = (r_sp == '0);
    assign w_full     = (r_sp == c_depth);
    assign w_pc_plus1 = r_pc + c_pc_one;
    assign w_push_idx = c_idx_w'(r_sp);
    assign w_top_idx  = c_idx_w'(r_sp - c_sp_one);

    // ret outranks call, so a call in a ret cycle is dropped silently.
    assign w_do_pop   = ret & ~w_empty;
    assign w_unf_set  = ret & w_empty;
    assign w_do_push  = ~ret & call & ~w_full;
    assign w_ovf_set  = ~ret & call & w_full;

    // Next PC by fixed priority: ret > call > load_pc > pc_inc > hold.
    always_comb begin
        w_pc_nxt = r_pc;
        if (ret) begin
            if (!w_empty) begin
                w_pc_nxt = r_stack[w_top_idx];
            end
        end else if (call) begin
            if (!w_full) begin
                w_pc_nxt = pc_in;
            end
        end else if (load_pc) begin
            w_pc_nxt = pc_in;
        end else if (pc_inc) begin
            w_pc_nxt = w_pc_plus1;
        end
    end

    // Next stack pointer; push and pop are mutually exclusive by construction.
    always_comb begin
        w_sp_nxt = r_sp;
        if (w_do_pop) begin
            w_sp_nxt = r_sp - c_sp_one;
        end else if (w_do_push) begin
            w_sp_nxt = r_sp + c_sp_one;
        end
    end

    // PC and stack pointer registers.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            r_pc <= c_reset_pc;
            r_sp <= '0;
        end else begin
            r_pc <= w_pc_nxt;
            r_sp <= w_sp_nxt;
        end
    end

    // Return-address storage; entries above the pointer are never read, so no reset.
    always_ff @(posedge clk) begin
        if (!reset_p && w_do_push) begin
            r_stack[w_push_idx] <= w_pc_plus1;
        end
    end

    // Sticky error flags; a fresh error beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ovf <= (r_ovf & ~clr_err) | w_ovf_set;
            r_unf <= (r_unf & ~clr_err) | w_unf_set;
        end
    end

    assign pc_out      = pc_rd_en ? r_pc : {ADDR_W{1'bz}};
    assign pc_cur      = r_pc;
    assign sp          = r_sp;
    assign stack_empty = w_empty;
    assign stack_full  = w_full;
    assign stack_ovf   = r_ovf;
    assign stack_unf   = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_program_seq_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_seq_unit
// Description : Directed scoreboard bench for program_seq_unit (ADDR_W=8,
//               STACK_DEPTH=4, RESET_ADDR=0). Stimulus pushes the expected
//               post-edge state; a monitor pops and compares after each edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_seq_unit;

    logic       clk = 1'b0;
    logic       reset_p = 1'b0;
    logic       pc_inc = 1'b0;
    logic       load_pc = 1'b0;
    logic       call = 1'b0;
    logic       ret = 1'b0;
    logic       clr_err = 1'b0;
    logic       pc_rd_en = 1'b0;
    logic [7:0] pc_in = 8'h00;
    wire  [7:0] pc_out;
    logic [7:0] pc_cur;
    logic [2:0] sp;
    logic       stack_empty;
    logic       stack_full;
    logic       stack_ovf;
    logic       stack_unf;

    typedef struct packed {
        logic [7:0] pc;
        logic [2:0] sp;
        logic       empty;
        logic       full;
        logic       ovf;
        logic       unf;
        logic [7:0] pcout;
    } exp_t;

    exp_t  exp_q [$];
    string name_q [$];
    int    checks   = 0;
    int    failures = 0;

    program_seq_unit #(
        .ADDR_W      (8),
        .STACK_DEPTH (4),
        .RESET_ADDR  (0)
    ) dut (
        .clk         (clk),
        .reset_p     (reset_p),
        .pc_inc      (pc_inc),
        .load_pc     (load_pc),
        .call        (call),
        .ret         (ret),
        .clr_err     (clr_err),
        .pc_rd_en    (pc_rd_en),
        .pc_in       (pc_in),
        .pc_out      (pc_out),
        .pc_cur      (pc_cur),
        .sp          (sp),
        .stack_empty (stack_empty),
        .stack_full  (stack_full),
        .stack_ovf   (stack_ovf),
        .stack_unf   (stack_unf)
    );

    always #5 clk = ~clk;

    // Monitor: one expectation per active edge, checked 1 time unit after it.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t  e;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if ({pc_cur, sp, stack_empty, stack_full, stack_ovf, stack_unf} !==
                {e.pc, e.sp, e.empty, e.full, e.ovf, e.unf}) begin
                failures++;
                $display("FAIL %s: got pc=%h sp=%0d emp=%b full=%b ovf=%b unf=%b, expected pc=%h sp=%0d emp=%b full=%b ovf=%b unf=%b",
                         n, pc_cur, sp, stack_empty, stack_full, stack_ovf, stack_unf,
                         e.pc, e.sp, e.empty, e.full, e.ovf, e.unf);
            end
            checks++;
            if (pc_out !== e.pcout) begin
                failures++;
                $display("FAIL %s_pc_out: got %h, expected %h", n, pc_out, e.pcout);
            end
        end
    end

    // Drive one cycle of controls and queue the state expected after the edge.
    task automatic step(input logic rst, input logic inc, input logic ld,
                        input logic cl, input logic rt, input logic clr,
                        input logic rd, input logic [7:0] din,
                        input logic [7:0] e_pc, input logic [2:0] e_sp,
                        input logic e_ovf, input logic e_unf, input string name);
        exp_t e;
        @(negedge clk);
        reset_p  = rst;
        pc_inc   = inc;
        load_pc  = ld;
        call     = cl;
        ret      = rt;
        clr_err  = clr;
        pc_rd_en = rd;
        pc_in    = din;
        e.pc     = e_pc;
        e.sp     = e_sp;
        e.empty  = (e_sp == 3'd0);
        e.full   = (e_sp == 3'd4);
        e.ovf    = e_ovf;
        e.unf    = e_unf;
        e.pcout  = rd ? e_pc : 8'hzz;
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    initial begin
        //    rst inc ld  cl  rt  clr rd  pc_in   pc     sp    ovf  unf
        step(1, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 3'd0, 0, 0, "reset");
        step(0, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 3'd0, 0, 0, "hold_after_reset");
        step(0, 1, 0, 0, 0, 0, 1, 8'h00, 8'h01, 3'd0, 0, 0, "inc1");
        step(0, 1, 0, 0, 0, 0, 1, 8'h00, 8'h02, 3'd0, 0, 0, "inc2");
        step(0, 1, 0, 0, 0, 0, 1, 8'h00, 8'h03, 3'd0, 0, 0, "inc3");
        step(0, 0, 1, 0, 0, 0, 1, 8'hFF, 8'hFF, 3'd0, 0, 0, "load_ff");
        step(0, 1, 0, 0, 0, 0, 1, 8'h00, 8'h00, 3'd0, 0, 0, "inc_wrap");
        step(0, 1, 1, 0, 0, 0, 1, 8'h10, 8'h10, 3'd0, 0, 0, "load_over_inc");
        step(0, 0, 0, 1, 0, 0, 1, 8'h40, 8'h40, 3'd1, 0, 0, "call_40");
        step(0, 0, 0, 1, 0, 0, 1, 8'h80, 8'h80, 3'd2, 0, 0, "call_80");
        step(0, 0, 0, 0, 1, 0, 1, 8'h00, 8'h41, 3'd1, 0, 0, "ret_41");
        step(0, 0, 0, 0, 1, 0, 1, 8'h00, 8'h11, 3'd0, 0, 0, "ret_11");
        step(0, 0, 0, 0, 1, 0, 1, 8'h00, 8'h11, 3'd0, 0, 1, "ret_empty_unf");
        step(0, 0, 0, 0, 1, 1, 1, 8'h00, 8'h11, 3'd0, 0, 1, "ret_clr_set_wins");
        step(0, 0, 0, 0, 0, 1, 1, 8'h00, 8'h11, 3'd0, 0, 0, "clr_unf");
        step(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h11, 3'd0, 0, 0, "hold_rd_off");
        step(0, 0, 0, 1, 0, 0, 1, 8'h20, 8'h20, 3'd1, 0, 0, "fill_1");
        step(0, 0, 0, 1, 0, 0, 1, 8'h30, 8'h30, 3'd2, 0, 0, "fill_2");
        step(0, 0, 0, 1, 0, 0, 1, 8'h50, 8'h50, 3'd3, 0, 0, "fill_3");
        step(0, 0, 0, 1, 0, 0, 1, 8'h60, 8'h60, 3'd4, 0, 0, "fill_4_full");
        step(0, 0, 0, 1, 0, 0, 1, 8'h70, 8'h60, 3'd4, 1, 0, "call_full_ovf");
        step(0, 1, 1, 1, 0, 0, 1, 8'h71, 8'h60, 3'd4, 1, 0, "call_full_masks_load");
        step(0, 0, 0, 0, 0, 1, 1, 8'h00, 8'h60, 3'd4, 0, 0, "clr_ovf");
        step(0, 0, 0, 1, 0, 1, 1, 8'h72, 8'h60, 3'd4, 1, 0, "call_clr_set_wins");
        step(0, 0, 0, 0, 0, 1, 1, 8'h00, 8'h60, 3'd4, 0, 0, "clr_ovf2");
        step(0, 0, 0, 1, 1, 0, 1, 8'h73, 8'h51, 3'd3, 0, 0, "ret_call_full_no_ovf");
        step(0, 0, 0, 1, 0, 0, 1, 8'h60, 8'h60, 3'd4, 0, 0, "refill_4");
        step(0, 0, 1, 0, 0, 0, 1, 8'h99, 8'h99, 3'd4, 0, 0, "load_full");
        step(0, 0, 0, 0, 1, 0, 1, 8'h00, 8'h52, 3'd3, 0, 0, "pop_52");
        step(0, 0, 0, 0, 1, 0, 1, 8'h00, 8'h31, 3'd2, 0, 0, "pop_31");
        step(0, 0, 0, 0, 1, 0, 1, 8'h00, 8'h21, 3'd1, 0, 0, "pop_21");
        step(0, 1, 1, 1, 1, 0, 0, 8'hAA, 8'h12, 3'd0, 0, 0, "all_ctrl_pop_only");
        step(0, 0, 0, 1, 0, 0, 1, 8'h40, 8'h40, 3'd1, 0, 0, "call_a");
        step(0, 0, 0, 1, 0, 0, 1, 8'h50, 8'h50, 3'd2, 0, 0, "call_b");
        step(1, 0, 0, 1, 0, 0, 1, 8'h77, 8'h00, 3'd0, 0, 0, "reset_with_call");
        step(0, 0, 0, 0, 1, 0, 1, 8'h00, 8'h00, 3'd0, 0, 1, "ret_after_reset_unf");
        step(1, 0, 0, 0, 1, 0, 1, 8'h00, 8'h00, 3'd0, 0, 0, "reset_with_ret");
        @(negedge clk);
        reset_p  = 1'b0;
        pc_inc   = 1'b0;
        load_pc  = 1'b0;
        call     = 1'b0;
        ret      = 1'b0;
        clr_err  = 1'b0;
        pc_rd_en = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/program_seq_unit.md
PROGRAM_SEQ_UNIT -- requirements
Module: program_seq_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, program address width in bits (4..16).
REQ-002 SHALL have parameter STACK_DEPTH, default 4, return-address stack entries (2..16).
REQ-003 SHALL have parameter RESET_ADDR, default 0, PC value after reset.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset_p  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port pc_inc  input  1  advance PC by one.
REQ-007 SHALL have port load_pc  input  1  jump: load pc_in into PC.
REQ-008 SHALL have port call  input  1  subroutine call: push return address, load pc_in.
REQ-009 SHALL have port ret  input  1  subroutine return: pop stack top into PC.
REQ-010 SHALL have port clr_err  input  1  clear sticky error flags.
REQ-011 SHALL have port pc_rd_en  input  1  drive PC onto pc_out bus.
REQ-012 SHALL have port pc_in  input  ADDR_W  jump/call target address.
REQ-013 SHALL have port pc_out  output  ADDR_W  PC when pc_rd_en=1, else high-impedance.
REQ-014 SHALL have port pc_cur  output  ADDR_W  PC, always driven.
REQ-015 SHALL have port sp  output  $clog2(STACK_DEPTH+1)  occupied stack entries.
REQ-016 SHALL have port stack_empty  output  1  sp==0.
REQ-017 SHALL have port stack_full  output  1  sp==STACK_DEPTH.
REQ-018 SHALL have port stack_ovf  output  1  sticky: call attempted while full.
REQ-019 SHALL have port stack_unf  output  1  sticky: ret attempted while empty.

Function
REQ-020 SHALL evaluate controls each cycle with fixed priority ret > call > load_pc > pc_inc > hold; lower-priority controls asserted in the same cycle are ignored.
REQ-021 SHALL, on pc_inc, set PC <= PC+1 modulo 2^ADDR_W (all-ones wraps to 0, no flag).
REQ-022 SHALL, on load_pc, set PC <= pc_in; stack unchanged.
REQ-023 SHALL, on call with stack not full, write (PC+1) mod 2^ADDR_W to entry sp, increment sp, set PC <= pc_in, all in one cycle.
REQ-024 SHALL, on call with stack full, leave PC, sp and stack contents unchanged and set stack_ovf.
REQ-025 SHALL, on ret with stack not empty, set PC <= entry sp-1 and decrement sp in one cycle.
REQ-026 SHALL, on ret with stack empty, leave PC and sp unchanged and set stack_unf.
REQ-027 SHALL, with call and ret asserted together, perform ret only (REQ-020); call is dropped without setting stack_ovf.
REQ-028 SHALL hold PC, sp and stack when no control is asserted.
REQ-029 SHALL reflect every update on pc_cur, sp, stack_empty, stack_full one cycle after the controlling edge (registered, latency 1).
REQ-030 SHALL drive pc_out combinationally from PC register and pc_rd_en; pc_rd_en has no effect on state.
REQ-031 SHALL clear stack_ovf and stack_unf on clr_err; a new error in the same cycle as clr_err SHALL leave its flag set (set wins).
REQ-032 SHALL keep stack_empty, stack_full derived from sp, never from separate state.
REQ-033 SHALL implement the stack as a register array; entries at index >= sp are don't-care and unobservable.

Reset
REQ-034 SHALL, on rising clk with reset_p=1, set PC=RESET_ADDR, sp=0, stack_ovf=0, stack_unf=0, overriding all other inputs.
REQ-035 SHALL, after reset, show pc_cur=RESET_ADDR, stack_empty=1, stack_full=0; pc_out per pc_rd_en.
REQ-036 SHALL abandon any in-flight call/ret in the reset cycle; no stack write or flag update occurs.

Verification
REQ-037 Reset then pc_inc for 3 cycles (ADDR_W=8) -> pc_cur 0,1,2,3; pc_in=8'hFF with load_pc then pc_inc -> 8'hFF then 8'h00.
REQ-038 PC=8'h10, call pc_in=8'h40; next call pc_in=8'h80; then ret, ret -> PC 8'h40, 8'h80, 8'h41, 8'h11; sp 1,2,1,0.
REQ-039 STACK_DEPTH=4: five consecutive calls -> sp=4, stack_full=1, 5th call leaves PC unchanged, stack_ovf=1; clr_err -> stack_ovf=0.
REQ-040 Reset then ret -> PC stays RESET_ADDR, stack_unf=1, sp=0; ret with clr_err same cycle on empty -> stack_unf stays 1.
REQ-041 Simultaneous ret+call+load_pc+pc_inc with sp=1 -> only pop occurs, sp=0, no flags; pc_rd_en=0 -> pc_out all Z, pc_cur valid.
REQ-042 reset_p asserted in same cycle as call with sp=2 -> PC=RESET_ADDR, sp=0, flags 0.
